fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage that sits directly upstream of the instruction ROM.
//  Owns the program counter and drives the ROM address each cycle.
//  Captures the ROM's combinational read data, together with its PC, into a small FIFO.
//  Presents {pc, instr} to decode over a valid/ready handshake. Handles redirects from branch/jump.
// PARAMETERS
//  DATA_WIDTH  32  instruction/ROM word width in bits; must be a multiple of 8
//  ADDR_WIDTH  32  PC and ROM address width (byte address)
//  RESET_PC    0   PC value loaded on reset
//  FIFO_DEPTH  2   instruction buffer entries; power of two, >= 2
// PORTS
//  clk_i          in   1           clock, rising edge
//  rst_i          in   1           reset, asynchronous, active-high
//  en_i           in   1           fetch enable
//  redirect_i     in   1           flush buffer and load new PC
//  redirect_pc_i  in   ADDR_WIDTH  redirect target (byte address)
//  addr_o         out  ADDR_WIDTH  ROM address (= PC register, registered)
//  data_i         in   DATA_WIDTH  ROM read data, combinational from addr_o
//  valid_o        out  1           FIFO head valid
//  ready_i        in   1           decode accepts head
//  instr_o        out  DATA_WIDTH  head instruction
//  pc_o           out  ADDR_WIDTH  head PC
//  misalign_o     out  1           misaligned-redirect trap (FETCH_MISALIGN_TRAP_EN only)
// BEHAVIOUR
//  Reset values: PC=RESET_PC, state=IDLE, FIFO empty, valid_o=0, misalign_o=0.
//    instr_o/pc_o are 0 while the FIFO is empty.
//  FSM states: IDLE, RUN, TRAP.
//    IDLE -> RUN when en_i=1.
//    RUN -> IDLE when en_i=0. Buffered entries remain and drain to decode.
//  Push: occurs in state RUN with !full && !redirect_i.
//    Writes {addr_o, data_i} to the FIFO.
//    Updates PC <= PC + DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
//  Pop: occurs when valid_o && ready_i. Same-cycle push and pop is legal at any count.
//  Full: no push and PC holds. Push does not depend on ready_i, so there is no combinational ready_i->addr_o path.
//  Empty: valid_o=0, and ready_i is ignored.
//  Latency: en_i seen high at edge N -> addr_o stable during cycle N -> valid_o=1 at cycle N+1.
//    With ready_i held high, one instruction is delivered per cycle.
//  Redirect (any state except TRAP):
//    FIFO count <= 0 and PC <= redirect_pc_i; no push that cycle.
//    A handshake occurring in the same cycle still counts as consumed; decode discards it.
//    The first fetch from the new PC comes one cycle after the redirect.
//  Redirect in IDLE: loads the PC and the state stays IDLE.
//  Reset mid-operation: immediate return to the reset values, regardless of handshake state.
// CONFIGURATION
//  Macro FETCH_MISALIGN_TRAP_EN, with it defined:
//    Redirect with redirect_pc_i[$clog2(DATA_WIDTH/8)-1:0] != 0 -> TRAP.
//    In TRAP: FIFO flushed, PC holds the offending value, misalign_o=1, no pushes.
//    TRAP exits only through reset.
//  Without the macro:
//    The low offset bits of redirect_pc_i are forced to 0 and the state never enters TRAP.
//    misalign_o is tied to 0.
// STRUCTURE
//  Package fetch_pkg:
//    PC_STEP = DATA_WIDTH/8.
//    OFFSET_BITS.
//    typedef enum fetch_state_t {IDLE, RUN, TRAP}.
//    typedef struct fetch_entry_t {pc, instr}.
//  Sub-module fetch_fifo: holds fetch_entry_t. Ports are push/pop/flush/full/empty.
//    Pointer wrap uses an extra MSB for full/empty detection.
//  The top level contains the PC register, the FSM and the redirect logic.
// TESTING
//  1 Reset, then en_i=1 and ready_i=1 -> pc_o sequence 0,4,8,12, one per cycle.
//    First valid_o arrives one cycle after the first enabled edge.
//  2 ready_i=0 for 5 cycles -> FIFO fills to 2 and addr_o holds at 8.
//    Release ready_i -> pc_o sequence 0,4,8 with no gaps or duplicates.
//  3 Redirect to 0x100 while 2 entries are buffered -> next cycle valid_o=0.
//    Then pc_o = 0x100, 0x104.
//  4 Force PC to 0xFFFFFFFC via redirect -> next pc_o wraps to 0x0.
//  5 Assert rst_i mid-stream while valid_o=1 and ready_i=0 -> valid_o=0 immediately and addr_o=0.
//  6 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_o=1 and valid_o=0.
//    No further addr_o changes until reset.
//    Without the macro, the same redirect yields pc_o=0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// Fetch-stage types and constants: entry layout, FSM states, PC step/offset widths.
// Purely declarative; no latency or backpressure of its own.
package fetch_pkg;

    localparam int FETCH_DATA_WIDTH = 32;
    localparam int FETCH_ADDR_WIDTH = 32;
    localparam int PC_STEP          = FETCH_DATA_WIDTH / 8;
    localparam int OFFSET_BITS      = $clog2(PC_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [FETCH_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small {pc, instr} buffer; head registered, visible one cycle after push.
// Pushes while full are dropped (caller gates them); flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    fetch_entry_t mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_entry;
    end

    assign head = empty ? '0 : mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC/FSM/redirect driving the ROM; valid one cycle after the fetch address, ready_i never gates addr_o.
// Misaligned-redirect trap is built only when FETCH_MISALIGN_TRAP_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  misalign_o
);

    localparam logic [ADDR_WIDTH-1:0] STEP        = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  redirect_take;
    logic                  misaligned;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  full;
    logic                  empty;
    fetch_entry_t          wr_entry;
    fetch_entry_t          head;

    // Once trapped, the PC must keep the offending address, so redirects are ignored.
    assign redirect_take = redirect_i && (state != TRAP);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned      = |(redirect_pc_i & OFFSET_MASK);
    assign redirect_target = redirect_pc_i;
`else
    assign misaligned      = 1'b0;
    assign redirect_target = redirect_pc_i & ~OFFSET_MASK;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (redirect_take && misaligned) state_next = TRAP;
                else if (en_i && !redirect_i)    state_next = RUN;
            end
            RUN: begin
                if (redirect_take && misaligned) state_next = TRAP;
                else if (!en_i)                  state_next = IDLE;
            end
            TRAP:    state_next = TRAP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        push       = (state == RUN) && !full && !redirect_i;
        flush      = redirect_take;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_o = (state == TRAP);
`else
        misalign_o = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)              pc <= RESET_PC;
        else if (redirect_take) pc <= redirect_target;
        else if (push)          pc <= pc + STEP;
    end

    assign addr_o         = pc;
    assign pop            = valid_o && ready_i;
    assign wr_entry.pc    = pc;
    assign wr_entry.instr = data_i;

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (push),
        .push_entry (wr_entry),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

    assign valid_o = !empty;
    assign instr_o = head.instr;
    assign pc_o    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset/trap sequences, and random traffic
// checked against a queue-based model of the fetch buffer.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] addr_o;
    logic [31:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        misalign_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    assign data_i = rom(addr_o);

    fetch_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .addr_o        (addr_o),
        .data_i        (data_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .misalign_o    (misalign_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic        rdy;
        logic        red;
        logic [31:0] rpc;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] addr;
    } vec_t;

    vec_t vt[$];

    task automatic row(input logic rs, input logic e, input logic r, input logic rd,
                       input logic [31:0] rpc, input logic v, input logic [31:0] p,
                       input logic [31:0] ad);
        vec_t x;
        x.rst = rs; x.en = e; x.rdy = r; x.red = rd; x.rpc = rpc;
        x.vld = v;  x.pc = p; x.addr = ad;
        vt.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; en_i = 1'b0; ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        tick();
        rst_i = 1'b0;
    endtask

    // Reference model state: buffered PCs in order, next fetch PC, fetching flag.
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    bit          m_run;

    initial begin
        // Stream, backpressure fill, redirect flush, wrap, redirect while idle.
        row(0,1,1,0,0,          0,0,0);
        row(0,1,1,0,0,          1,0,4);
        row(0,1,1,0,0,          1,4,8);
        row(0,1,1,0,0,          1,8,12);
        row(0,1,1,0,0,          1,12,16);
        row(1,0,0,0,0,          0,0,0);
        row(0,1,0,0,0,          0,0,0);
        row(0,1,0,0,0,          1,0,4);
        row(0,1,0,0,0,          1,0,8);
        row(0,1,0,0,0,          1,0,8);
        row(0,1,0,0,0,          1,0,8);
        row(0,1,1,0,0,          1,4,8);
        row(0,1,1,0,0,          1,8,12);
        row(0,1,0,0,0,          1,8,16);
        row(0,1,0,0,0,          1,8,16);
        row(0,1,0,1,32'h100,    0,0,32'h100);
        row(0,1,1,0,0,          1,32'h100,32'h104);
        row(0,1,1,0,0,          1,32'h104,32'h108);
        row(0,1,1,1,32'hFFFF_FFFC, 0,0,32'hFFFF_FFFC);
        row(0,1,1,0,0,          1,32'hFFFF_FFFC,0);
        row(0,1,1,0,0,          1,0,4);
        row(0,0,1,0,0,          1,4,8);
        row(0,0,1,0,0,          0,0,8);
        row(0,1,1,1,32'h40,     0,0,32'h40);
        row(0,1,1,0,0,          0,0,32'h40);
        row(0,1,1,0,0,          1,32'h40,32'h44);

        do_reset();
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_addr", addr_o, 32'd0);
        check("reset_pc", pc_o, 32'd0);
        check("reset_instr", instr_o, 32'd0);
        check("reset_misalign", 32'(misalign_o), 32'd0);

        foreach (vt[i]) begin
            rst_i = vt[i].rst; en_i = vt[i].en; ready_i = vt[i].rdy;
            redirect_i = vt[i].red; redirect_pc_i = vt[i].rpc;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vt[i].vld));
            check($sformatf("vec%0d_pc", i), pc_o, vt[i].pc);
            check($sformatf("vec%0d_instr", i), instr_o, vt[i].vld ? rom(vt[i].pc) : 32'd0);
            check($sformatf("vec%0d_addr", i), addr_o, vt[i].addr);
            check($sformatf("vec%0d_misalign", i), 32'(misalign_o), 32'd0);
        end

        // Asynchronous reset with a stalled, valid head.
        rst_i = 1'b0; redirect_i = 1'b0; en_i = 1'b1; ready_i = 1'b0;
        tick();
        check("pre_rst_valid", 32'(valid_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_valid", 32'(valid_o), 32'd0);
        check("async_rst_addr", addr_o, 32'd0);
        check("async_rst_pc", pc_o, 32'd0);
        tick();
        rst_i = 1'b0;

        // Misaligned redirect.
        en_i = 1'b1; ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h102;
        tick();
        redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_misalign", 32'(misalign_o), 32'd1);
        check("trap_valid", 32'(valid_o), 32'd0);
        check("trap_addr", addr_o, 32'h102);
        for (int k = 0; k < 4; k++) begin
            redirect_i = (k == 1); redirect_pc_i = 32'h200;
            tick();
            check($sformatf("trap_hold%0d_addr", k), addr_o, 32'h102);
            check($sformatf("trap_hold%0d_misalign", k), 32'(misalign_o), 32'd1);
            check($sformatf("trap_hold%0d_valid", k), 32'(valid_o), 32'd0);
        end
        redirect_i = 1'b0;
`else
        check("align_addr", addr_o, 32'h100);
        check("align_misalign", 32'(misalign_o), 32'd0);
        tick();
        tick();
        check("align_valid", 32'(valid_o), 32'd1);
        check("align_pc", pc_o, 32'h100);
        check("align_instr", instr_o, rom(32'h100));
`endif

        // Random traffic against the queue model.
        do_reset();
        m_q.delete();
        m_pc  = 32'd0;
        m_run = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bit          pop;
            bit          push;
            logic [31:0] rpc;
            en_i       = ($urandom_range(0, 9) != 0);
            ready_i    = ($urandom_range(0, 2) != 0);
            redirect_i = ($urandom_range(0, 15) == 0);
            rpc        = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            rpc        = rpc & 32'hFFFF_FFFC;
`endif
            redirect_pc_i = rpc;
            pop  = (m_q.size() > 0) && ready_i;
            push = m_run && (m_q.size() < 2) && !redirect_i;
            tick();
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (redirect_i) begin
                m_q.delete();
                m_pc = rpc & 32'hFFFF_FFFC;
            end
            m_run = m_run ? en_i : (en_i && !redirect_i);
            check("rnd_valid", 32'(valid_o), 32'(m_q.size() > 0));
            check("rnd_pc", pc_o, (m_q.size() > 0) ? m_q[0] : 32'd0);
            check("rnd_instr", instr_o, (m_q.size() > 0) ? rom(m_q[0]) : 32'd0);
            check("rnd_addr", addr_o, m_pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
